// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: Moore main FSM plus ALU decoder.
// Write enables are masked while reset is high. Every other output follows the state register.

// ALU decoder: maps the 2-bit aluop class and the funct field to a 3-bit ALU operation.
module aludecoder (
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);
    // 00 selects add for address/PC math, 01 selects subtract for beq, and otherwise funct decides.
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b00:   alucontrol = 3'b010;
            2'b01:   alucontrol = 3'b110;
            default: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b000;
                endcase
            end
        endcase
    end
endmodule

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q, state_n;
    logic       pcwrite, branch;
    logic       irwrite_s, memwrite_s, regwrite_s;
    logic [1:0] aluop;

    // State register. Reset returns to FETCH from any state, including mid-instruction.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_n;
    end

    // Next-state logic. Unknown opcodes and unused encodings fall back to FETCH.
    always_comb begin
        state_n = FETCH;
        case (state_q)
            FETCH:   state_n = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYP:      state_n = EXECUTE;
                    OP_BEQ:       state_n = BRANCH;
                    OP_ADDI:      state_n = ADDIEX;
                    OP_J:         state_n = JUMP;
                    default:      state_n = FETCH;
                endcase
            end
            MEMADR:  state_n = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_n = MEMWB;
            EXECUTE: state_n = ALUWB;
            ADDIEX:  state_n = ADDIWB;
            default: state_n = FETCH;
        endcase
    end

    // Moore outputs. Anything a state does not drive stays 0.
    always_comb begin
        iord       = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = 2'b00;
        case (state_q)
            FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIWB:  regwrite_s = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are masked while reset is held, so no architectural state changes mid-reset.
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign irwrite  = ~reset & irwrite_s;
    assign memwrite = ~reset & memwrite_s;
    assign regwrite = ~reset & regwrite_s;
    assign state    = state_q;

    aludecoder u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings are fixed.
REQ-002 clk  in  1  single clock; all state changes occur on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction opcode field instr[31:26], sampled in DECODE.
REQ-005 funct  in  6  instruction funct field instr[5:0].
REQ-006 zero  in  1  ALU zero flag.
REQ-007 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 memwrite  out  1  data memory write enable.
REQ-009 irwrite  out  1  instruction register load enable.
REQ-010 regdst  out  1  write-register select: 1 = rd, 0 = rt.
REQ-011 memtoreg  out  1  writeback select: 1 = memory data, 0 = ALUOut.
REQ-012 regwrite  out  1  register file write enable.
REQ-013 alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
REQ-014 alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
REQ-015 pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-016 pcen  out  1  PC load enable.
REQ-017 alucontrol  out  3  ALU operation code.
REQ-018 state  out  4  current state encoding, exposed for debug and verification.

Function
REQ-019 The block SHALL be a Moore FSM with a registered 4-bit state and these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-020 Transitions SHALL be as follows.
- FETCH->DECODE.
- DECODE->MEMADR for op=100011 (lw) or op=101011 (sw); EXECUTE for 000000 (R-type); BRANCH for 000100 (beq); ADDIEX for 001000 (addi); JUMP for 000010 (j); FETCH for any other op (executes as a nop).
- MEMADR->MEMRD if lw, MEMWR if sw.
- MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP each SHALL return to FETCH.
- Encodings 12-15 SHALL go to FETCH on the next edge.
REQ-021 Outputs SHALL depend only on state, except pcen and alucontrol. Any output not listed for a state SHALL be 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1, regdst=0.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-022 pcen SHALL equal pcwrite OR (branch AND zero), combinationally.
REQ-023 The internal aluop SHALL map to alucontrol by instantiating the existing aludecoder, with the mapping:
- aluop 00 -> 010.
- aluop 01 -> 110.
- otherwise by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, else 000.
REQ-024 Per-instruction latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
REQ-025 op and funct SHALL NOT be registered inside the block; the datapath IR holds them stable after FETCH.

Reset
REQ-026 When reset=1 at a rising edge, state SHALL become FETCH regardless of the current state, including mid-instruction.
REQ-027 While reset=1, pcen, irwrite, memwrite and regwrite SHALL be forced to 0; all other outputs SHALL follow the current state.
REQ-028 In the first cycle after reset deasserts, the block SHALL be in FETCH with irwrite=1 and pcen=1.

Verification
REQ-029 Reset held 2 cycles, then released -> state=0, pcen=1, irwrite=1, alusrcb=01, alucontrol=010.
REQ-030 lw (op=100011) -> states 0,1,2,3,4,0; memtoreg=1 and regwrite=1 only in state 4; iord=1 in state 3.
REQ-031 R-type (op=000000) with funct 100010, then a second R-type with funct 101010 -> state 6 shows alucontrol=110, then 111; regdst=1 and regwrite=1 in state 7; sw (op=101011) -> states 0,1,2,5,0 with memwrite=1 only in state 5.
REQ-032 beq (op=000100) with zero=1 -> in state 8: pcen=1, pcsrc=01, alucontrol=110; repeat with zero=0 -> pcen=0.
REQ-033 j (op=000010) -> states 0,1,11,0 with pcsrc=10 and pcen=1 in state 11; illegal op=111111 -> states 0,1,0 with no write enables asserted.
REQ-034 reset asserted while in state 3 (MEMRD) -> next state=0; regwrite never asserted; memwrite and regwrite=0 during reset.
